// File: rtl/sha512_msg_ctrl.sv
// Message-level sequencer wrapping a single-chunk SHA-512 compression core.
// Optional SHA-384 support is enabled by defining SHA512_MSG_CTRL_SHA384_EN.
module sha512_msg_ctrl #(
    parameter int WATCHDOG_CYCLES = 512,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1023:0]      in_chunk,
    input  logic               in_last,
`ifdef SHA512_MSG_CTRL_SHA384_EN
    input  logic               mode_384,
`endif
    output logic               core_rst_n,
    input  logic               core_done,
    output logic [1023:0]      core_chunk,
    output logic [511:0]       core_h_in,
    input  logic [511:0]       core_h_out,
    output logic               digest_valid,
    input  logic               digest_ready,
    output logic [511:0]       digest,
    output logic [CNT_W-1:0]   chunk_cnt,
    output logic               error
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

`ifdef SHA512_MSG_CTRL_SHA384_EN
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        UPDATE,
        OUT
    } state_t;

    state_t             state_q,       state_d;
    logic [511:0]       hState_q,      hState_d;
    logic [1023:0]      chunk_q,       chunk_d;
    logic               last_q,        last_d;
    logic               firstFlag_q,   firstFlag_d;
    logic [WD_W-1:0]    wdCnt_q,       wdCnt_d;
    logic               inReady_q,     inReady_d;
    logic               coreRstN_q,    coreRstN_d;
    logic               digestValid_q, digestValid_d;
    logic [511:0]       digest_q,      digest_d;
    logic [CNT_W-1:0]   chunkCnt_q,    chunkCnt_d;
    logic               error_q,       error_d;
`ifdef SHA512_MSG_CTRL_SHA384_EN
    logic               mode384_q,     mode384_d;
`endif

    // Every output is a register; next values are chosen to match the state being entered.
    always_comb begin
        state_d       = state_q;
        hState_d      = hState_q;
        chunk_d       = chunk_q;
        last_d        = last_q;
        firstFlag_d   = firstFlag_q;
        wdCnt_d       = wdCnt_q;
        inReady_d     = inReady_q;
        coreRstN_d    = coreRstN_q;
        digestValid_d = digestValid_q;
        digest_d      = digest_q;
        chunkCnt_d    = chunkCnt_q;
        error_d       = error_q;
`ifdef SHA512_MSG_CTRL_SHA384_EN
        mode384_d     = mode384_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && inReady_q) begin
                    chunk_d   = in_chunk;
                    last_d    = in_last;
                    inReady_d = 1'b0;
                    state_d   = LOAD;
                    if (firstFlag_q) begin
                        firstFlag_d = 1'b0;
                        chunkCnt_d  = '0;
`ifdef SHA512_MSG_CTRL_SHA384_EN
                        mode384_d   = mode_384;
                        hState_d    = mode_384 ? IV384 : IV512;
`else
                        hState_d    = IV512;
`endif
                    end
                end
            end

            LOAD: begin
                wdCnt_d    = '0;
                coreRstN_d = 1'b1;
                state_d    = RUN;
            end

            // A timeout throws the chunk away and forces the next chunk to restart from the IV.
            RUN: begin
                if (core_done) begin
                    coreRstN_d = 1'b0;
                    state_d    = UPDATE;
                end else if (wdCnt_q == WD_LAST) begin
                    error_d     = 1'b1;
                    firstFlag_d = 1'b1;
                    coreRstN_d  = 1'b0;
                    inReady_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wdCnt_d = wdCnt_q + WD_W'(1);
                end
            end

            UPDATE: begin
                hState_d = core_h_out;
                if (chunkCnt_q != {CNT_W{1'b1}}) begin
                    chunkCnt_d = chunkCnt_q + CNT_W'(1);
                end
                if (last_q) begin
`ifdef SHA512_MSG_CTRL_SHA384_EN
                    digest_d = mode384_q ? {core_h_out[511:128], 128'd0} : core_h_out;
`else
                    digest_d = core_h_out;
`endif
                    digestValid_d = 1'b1;
                    state_d       = OUT;
                end else begin
                    inReady_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            OUT: begin
                if (digest_ready) begin
                    digestValid_d = 1'b0;
                    firstFlag_d   = 1'b1;
                    chunkCnt_d    = '0;
                    inReady_d     = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d       = IDLE;
                inReady_d     = 1'b1;
                coreRstN_d    = 1'b0;
                digestValid_d = 1'b0;
                firstFlag_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hState_q      <= IV512;
            chunk_q       <= '0;
            last_q        <= 1'b0;
            firstFlag_q   <= 1'b1;
            wdCnt_q       <= '0;
            inReady_q     <= 1'b1;
            coreRstN_q    <= 1'b0;
            digestValid_q <= 1'b0;
            digest_q      <= '0;
            chunkCnt_q    <= '0;
            error_q       <= 1'b0;
`ifdef SHA512_MSG_CTRL_SHA384_EN
            mode384_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hState_q      <= hState_d;
            chunk_q       <= chunk_d;
            last_q        <= last_d;
            firstFlag_q   <= firstFlag_d;
            wdCnt_q       <= wdCnt_d;
            inReady_q     <= inReady_d;
            coreRstN_q    <= coreRstN_d;
            digestValid_q <= digestValid_d;
            digest_q      <= digest_d;
            chunkCnt_q    <= chunkCnt_d;
            error_q       <= error_d;
`ifdef SHA512_MSG_CTRL_SHA384_EN
            mode384_q     <= mode384_d;
`endif
        end
    end

    assign in_ready     = inReady_q;
    assign core_rst_n   = coreRstN_q;
    assign core_chunk   = chunk_q;
    assign core_h_in    = hState_q;
    assign digest_valid = digestValid_q;
    assign digest       = digest_q;
    assign chunk_cnt    = chunkCnt_q;
    assign error        = error_q;

endmodule

// File: tb/tb_sha512_msg_ctrl.sv
// Self-checking bench for sha512_msg_ctrl with a behavioural SHA-512 core and a message-level reference hash.
// Exercises the SHA-384 mode as well when SHA512_MSG_CTRL_SHA384_EN is defined.
module tb_sha512_msg_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_chunk;
    logic          in_last;
    logic          core_rst_n;
    logic          core_done;
    logic [1023:0] core_chunk;
    logic [511:0]  core_h_in;
    logic [511:0]  core_h_out;
    logic          digest_valid;
    logic          digest_ready;
    logic [511:0]  digest;
    logic [15:0]   chunk_cnt;
    logic          error;
`ifdef SHA512_MSG_CTRL_SHA384_EN
    logic          mode_384;
`endif

    int errorCount = 0;
    int checkCount = 0;
    int coreLat    = 20;
    logic coreStall = 1'b0;
    int coreCycles = 0;

    logic [1023:0] msgChunks [4];

    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };
    localparam logic [511:0] ABC512 = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
    };

    sha512_msg_ctrl dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_chunk(in_chunk),
        .in_last(in_last),
`ifdef SHA512_MSG_CTRL_SHA384_EN
        .mode_384(mode_384),
`endif
        .core_rst_n(core_rst_n),
        .core_done(core_done),
        .core_chunk(core_chunk),
        .core_h_in(core_h_in),
        .core_h_out(core_h_out),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready),
        .digest(digest),
        .chunk_cnt(chunk_cnt),
        .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] blk);
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] s0, s1, t1, t2;
        logic [511:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[1023 - 64*i -: 64];
        for (int i = 16; i < 80; i++) begin
            s0 = ror(w[i-15], 1) ^ ror(w[i-15], 8) ^ (w[i-15] >> 7);
            s1 = ror(w[i-2], 19) ^ ror(w[i-2], 61) ^ (w[i-2] >> 6);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) v[j] = hin[511 - 64*j -: 64];
        for (int i = 0; i < 80; i++) begin
            t1 = v[7] + (ror(v[4], 14) ^ ror(v[4], 18) ^ ror(v[4], 41))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (ror(v[0], 28) ^ ror(v[0], 34) ^ ror(v[0], 39))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[511 - 64*j -: 64] = hin[511 - 64*j -: 64] + v[j];
        return res;
    endfunction

    // Whole-message hash of the first n entries of msgChunks.
    function automatic logic [511:0] refHash(input int n, input bit is384);
        logic [511:0] h;
        h = is384 ? IV384 : IV512;
        for (int i = 0; i < n; i++) h = compress(h, msgChunks[i]);
        if (is384) h[127:0] = '0;
        return h;
    endfunction

    function automatic logic [1023:0] randChunk();
        logic [1023:0] c;
        for (int i = 0; i < 32; i++) c[32*i +: 32] = $urandom;
        return c;
    endfunction

    // Core stand-in: restarts whenever held in reset, raises done coreLat cycles after release.
    always @(posedge clk) begin
        if (core_rst_n !== 1'b1) begin
            coreCycles <= 0;
            core_done  <= 1'b0;
        end else if (core_done !== 1'b1 && !coreStall) begin
            if (coreCycles == coreLat - 1) begin
                core_h_out <= compress(core_h_in, core_chunk);
                core_done  <= 1'b1;
            end
            coreCycles <= coreCycles + 1;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1023:0] chunk, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_chunk = chunk;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitFor(input string tag, input bit forDigest);
        int n;
        n = 0;
        while ((forDigest ? digest_valid : in_ready) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, forDigest ? digest_valid : in_ready, 1'b1);
    endtask

    task automatic runMessage(input int n, input bit is384, input int rdyDelay);
`ifdef SHA512_MSG_CTRL_SHA384_EN
        mode_384 = is384;
`endif
        for (int i = 0; i < n; i++) begin
            applyStimulus(msgChunks[i], i == n - 1);
            if (i != n - 1) begin
                waitFor("mid_ready", 1'b0);
                checkOutput("mid_no_digest", digest_valid, 1'b0);
                checkOutput("mid_chunk_cnt", chunk_cnt, 16'(i + 1));
            end
        end
        waitFor("digest_wait", 1'b1);
        checkOutput("digest_value", digest, refHash(n, is384));
        checkOutput("out_chunk_cnt", chunk_cnt, 16'(n));
        checkOutput("out_in_ready", in_ready, 1'b0);
        repeat (rdyDelay) @(negedge clk);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        checkOutput("post_valid", digest_valid, 1'b0);
        checkOutput("post_ready", in_ready, 1'b1);
        checkOutput("post_cnt", chunk_cnt, 16'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_digest_valid", digest_valid, 1'b0);
        checkOutput("rst_digest", digest, 512'd0);
        checkOutput("rst_chunk_cnt", chunk_cnt, 16'd0);
        checkOutput("rst_error", error, 1'b0);
        checkOutput("rst_core_rst_n", core_rst_n, 1'b0);
        checkOutput("rst_h_iv", core_h_in, IV512);
    endtask

    initial begin
        logic [1023:0] abcBlk, nistA, nistB;
        string nist2;
        int n;

        reset = 1'b1; in_valid = 1'b0; in_chunk = '0; in_last = 1'b0; digest_ready = 1'b0;
`ifdef SHA512_MSG_CTRL_SHA384_EN
        mode_384 = 1'b0;
`endif
        abcBlk = '0;
        abcBlk[1023:992] = 32'h61626380;
        abcBlk[7:0] = 8'h18;
        nist2 = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
        nistA = '0;
        for (int i = 0; i < nist2.len(); i++) nistA[1023 - 8*i -: 8] = nist2[i];
        nistA[1023 - 8*112 -: 8] = 8'h80;
        nistB = '0;
        nistB[127:0] = 128'd896;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkResetState();

        // "abc" with the consumer stalling for 100 cycles.
        $display("[TB] abc with digest back-pressure");
        coreLat = 310;
        applyStimulus(abcBlk, 1'b1);
        waitFor("abc_digest_wait", 1'b1);
        checkOutput("abc_digest", digest, ABC512);
        checkOutput("abc_cnt", chunk_cnt, 16'd1);
        in_valid = 1'b1;
        in_chunk = randChunk();
        in_last  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", digest_valid, 1'b1);
            checkOutput("hold_in_ready", in_ready, 1'b0);
            checkOutput("hold_digest", digest, ABC512);
            checkOutput("hold_core_rst", core_rst_n, 1'b0);
        end
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        in_valid = 1'b0;
        checkOutput("release_valid", digest_valid, 1'b0);
        checkOutput("release_ready", in_ready, 1'b1);
        checkOutput("release_digest_kept", digest, ABC512);

        // Two-chunk NIST message.
        $display("[TB] two-chunk message");
        coreLat = 40;
        msgChunks[0] = nistA;
        msgChunks[1] = nistB;
        runMessage(2, 1'b0, 3);
        checkOutput("nist2_hi", digest[511:448], 64'h8e959b75dae313da);
        checkOutput("nist2_lo", digest[31:0], 32'h874be909);

        // Reset in the middle of a message, then a fresh "abc".
        $display("[TB] reset during RUN");
        coreLat = 200;
        applyStimulus(nistA, 1'b0);
        @(negedge clk);
        checkOutput("midrun_core_on", core_rst_n, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetState();
        coreLat = 25;
        msgChunks[0] = abcBlk;
        runMessage(1, 1'b0, 0);
        checkOutput("after_reset_abc", digest, ABC512);
        checkOutput("after_reset_err", error, 1'b0);

        // Core never finishes: watchdog fires after exactly 512 RUN cycles.
        $display("[TB] watchdog");
        coreStall = 1'b1;
        applyStimulus(randChunk(), 1'b0);
        @(negedge clk);
        checkOutput("wd_run_entered", core_rst_n, 1'b1);
        n = 0;
        while (error !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wd_cycles", n, 512);
        checkOutput("wd_in_ready", in_ready, 1'b1);
        checkOutput("wd_core_rst", core_rst_n, 1'b0);
        coreStall = 1'b0;
        coreLat = 30;
        runMessage(1, 1'b0, 1);
        checkOutput("wd_then_abc", digest, ABC512);
        checkOutput("wd_sticky", error, 1'b1);

        // Random multi-chunk messages against the reference hash.
        $display("[TB] random messages");
        for (int m = 0; m < 6; m++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) msgChunks[i] = randChunk();
            coreLat = $urandom_range(3, 60);
            runMessage(n, 1'b0, $urandom_range(0, 4));
        end

`ifdef SHA512_MSG_CTRL_SHA384_EN
        $display("[TB] SHA-384 abc");
        msgChunks[0] = abcBlk;
        coreLat = 50;
        runMessage(1, 1'b1, 2);
        checkOutput("abc384_hi", digest[511:448], 64'hcb00753f45a35e8b);
        checkOutput("abc384_w5", digest[191:128], 64'h58baeca134c825a7);
        checkOutput("abc384_lo", digest[127:0], 128'd0);
        msgChunks[0] = randChunk();
        runMessage(1, 1'b0, 0);
`endif

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("final_err_clear", error, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
